// File: rtl/layer_learn_sequencer.sv
// layer_learn_sequencer: fetch/forward/settle/learn training sequencer for a neuron_learn layer.
// Optional abort input enabled by defining LAYER_SEQ_ABORT_EN.
module layer_learn_sequencer #(
  parameter int SAMPLE_W = 8,
  parameter int EPOCH_W  = 10,
  parameter int SETTLE   = 2
) (
  input  logic                clock,
  input  logic                reset,
`ifdef LAYER_SEQ_ABORT_EN
  input  logic                abort,
`endif
  input  logic                start,
  input  logic [SAMPLE_W-1:0] num_samples,
  input  logic [EPOCH_W-1:0]  num_epochs,
  input  logic                smp_valid,
  output logic                smp_ready,
  output logic [SAMPLE_W-1:0] smp_index,
  output logic                layer_valid,
  output logic                layer_learn,
  output logic [EPOCH_W-1:0]  epoch,
  output logic                busy,
  output logic                done
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_FORWARD, S_SETTLE, S_LEARN, S_DONE} state_t;
  localparam logic [3:0] SLAST = 4'(SETTLE > 0 ? SETTLE - 1 : 0);
  state_t state, next;
  logic [SAMPLE_W-1:0] n_smp;
  logic [EPOCH_W-1:0] n_ep;
  logic [3:0] cnt;
  logic last_smp, last_ep, accept, abort_now, learn_fire;
  assign last_smp = smp_index == n_smp - SAMPLE_W'(1);
  assign last_ep = epoch == n_ep - EPOCH_W'(1);
  assign accept = start && (state == S_IDLE || state == S_DONE);
`ifdef LAYER_SEQ_ABORT_EN
  assign abort_now = abort && busy;
`else
  assign abort_now = 1'b0;
`endif
  always_ff @(posedge clock)
    if (reset) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      S_IDLE, S_DONE: if (start) next = (num_samples == '0 || num_epochs == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (smp_valid) next = S_FORWARD;
      S_FORWARD: next = SETTLE == 0 ? S_LEARN : S_SETTLE;
      S_SETTLE: if (cnt == SLAST) next = S_LEARN;
      S_LEARN: next = (last_smp && last_ep) ? S_DONE : S_FETCH;
      default: next = S_IDLE;
    endcase
    if (abort_now) next = S_IDLE;
  end
  // abort in the LEARN cycle suppresses the learn strobe and the sample consume
  always_comb begin
    busy = state == S_FETCH || state == S_FORWARD || state == S_SETTLE || state == S_LEARN;
    done = state == S_DONE;
    learn_fire = state == S_LEARN && !abort_now;
    layer_valid = state == S_FORWARD || learn_fire;
    layer_learn = learn_fire;
    smp_ready = learn_fire;
  end
  always_ff @(posedge clock)
    if (reset || abort_now) begin
      smp_index <= '0;
      epoch <= '0;
      cnt <= '0;
      if (reset) begin
        n_smp <= '0;
        n_ep <= '0;
      end
    end else if (accept) begin
      n_smp <= num_samples;
      n_ep <= num_epochs;
      smp_index <= '0;
      epoch <= '0;
      cnt <= '0;
    end else if (state == S_SETTLE) cnt <= cnt + 4'd1;
    else if (state == S_LEARN) begin
      cnt <= '0;
      smp_index <= last_smp ? '0 : smp_index + SAMPLE_W'(1);
      if (last_smp && !last_ep) epoch <= epoch + EPOCH_W'(1);
    end
endmodule

// File: tb/tb_layer_learn_sequencer.sv
// tb_layer_learn_sequencer: directed checks of the default (no abort) build with SETTLE=2.
module tb_layer_learn_sequencer;
  logic clock = 0, reset = 1, start = 0, smp_valid = 0;
  logic [7:0] num_samples = 0;
  logic [9:0] num_epochs = 0;
  logic smp_ready, layer_valid, layer_learn, busy, done;
  logic [7:0] smp_index;
  logic [9:0] epoch;
  int checks = 0, errors = 0;
  int cyc, learns, fwds;
  int lcyc[$], lidx[$], lep[$];
  int done_cyc;

  layer_learn_sequencer #(.SAMPLE_W(8), .EPOCH_W(10), .SETTLE(2)) dut (
    .clock(clock), .reset(reset), .start(start), .num_samples(num_samples),
    .num_epochs(num_epochs), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_index(smp_index), .layer_valid(layer_valid), .layer_learn(layer_learn),
    .epoch(epoch), .busy(busy), .done(done));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_to_done(input int max, output int nl, output int nf);
    int n = 0;
    nl = 0;
    nf = 0;
    while (!done && n < max) begin
      if (layer_learn) nl++;
      if (layer_valid && !layer_learn) nf++;
      step();
      n++;
    end
    chk("run_timeout", done, 1);
  endtask

  initial begin
    step();
    step();
    reset = 0;
    chk("reset_outs", {smp_ready, layer_valid, layer_learn, busy, done, smp_index, epoch}, 0);
    // basic run: 3 samples x 2 epochs
    num_samples = 3;
    num_epochs = 2;
    smp_valid = 1;
    start = 1;
    step();
    start = 0;
    cyc = 1;
    chk("start_fetch", {busy, smp_index, epoch}, {1'b1, 8'd0, 10'd0});
    done_cyc = -1;
    fwds = 0;
    for (int i = 0; i < 40; i++) begin
      if (layer_learn) begin
        lcyc.push_back(cyc);
        lidx.push_back(smp_index);
        lep.push_back(epoch);
        chk("learn_ready", {smp_ready, layer_valid}, 2'b11);
      end
      if (layer_valid && !layer_learn) fwds++;
      if (done && done_cyc < 0) done_cyc = cyc;
      step();
      cyc++;
    end
    chk("learn_count", lcyc.size(), 6);
    chk("fwd_count", fwds, 6);
    chk("done_cycle", done_cyc, 31);
    if (lcyc.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("learn_cyc%0d", i), lcyc[i], 5 + 5 * i);
        chk($sformatf("learn_idx%0d", i), lidx[i], i % 3);
        chk($sformatf("learn_ep%0d", i), lep[i], i / 3);
      end
    chk("done_hold", {done, busy, smp_index, epoch}, {1'b1, 1'b0, 8'd0, 10'd1});
    // zero samples: straight to DONE
    num_samples = 0;
    start = 1;
    step();
    start = 0;
    chk("zero_done", {done, busy}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      chk("zero_quiet", {layer_valid, smp_ready}, 0);
      step();
    end
    // smp_valid low for 4 FETCH cycles
    num_samples = 2;
    num_epochs = 1;
    smp_valid = 0;
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_fetch", {busy, layer_valid, smp_index, epoch}, {1'b1, 1'b0, 8'd0, 10'd0});
      step();
    end
    smp_valid = 1;
    step();
    chk("stall_forward", {layer_valid, layer_learn, smp_index}, {1'b1, 1'b0, 8'd0});
    run_to_done(50, learns, fwds);
    chk("stall_learns", learns, 2);
    // start while busy at sample 1
    num_samples = 3;
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 6; i++) step();
    chk("busy_pre", {busy, layer_valid, smp_index}, {1'b1, 1'b1, 8'd1});
    num_samples = 9;
    start = 1;
    step();
    start = 0;
    chk("busy_ignore", {busy, smp_index, epoch}, {1'b1, 8'd1, 10'd0});
    run_to_done(50, learns, fwds);
    chk("busy_learns", learns, 2);
    chk("busy_final", {smp_index, epoch}, 0);
    // reset during SETTLE
    num_samples = 3;
    num_epochs = 2;
    start = 1;
    step();
    start = 0;
    step();
    step();
    chk("pre_reset_settle", {busy, layer_valid}, 2'b10);
    reset = 1;
    step();
    reset = 0;
    chk("mid_reset", {smp_ready, layer_valid, layer_learn, busy, done, smp_index, epoch}, 0);
    learns = 0;
    for (int i = 0; i < 10; i++) begin
      if (layer_learn) learns++;
      step();
    end
    chk("reset_no_learn", learns, 0);
    start = 1;
    step();
    start = 0;
    chk("restart", {busy, smp_index, epoch}, {1'b1, 8'd0, 10'd0});
    run_to_done(80, learns, fwds);
    chk("restart_learns", learns, 6);
    chk("restart_fwds", fwds, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
